// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package adder_pkg;

    localparam int CLA_GRP = 4;

    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

    // Group generate/propagate of one 4-bit group, flat sum-of-products form
    function automatic cla_gp_t group_gp(input logic [CLA_GRP-1:0] g,
                                         input logic [CLA_GRP-1:0] p);
        cla_gp_t r;
        logic    t;
        r.p = &p;
        r.g = 1'b0;
        for (int i = 0; i < CLA_GRP; i++) begin
            t = g[i];
            for (int m = i + 1; m < CLA_GRP; m++) t = t & p[m];
            r.g = r.g | t;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle of the pipelined CLA adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/pipelined_cla_adder_cla_segment.sv
// One combinational carry-lookahead segment: 4-bit groups with a
// segment-level lookahead across groups (no ripple between groups).
module cla_segment
    import adder_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    localparam int NG = SEG / CLA_GRP;

    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG:0]    gc;
    cla_gp_t        gp [NG];

    assign p = a ^ b;
    assign g = a & b;

    // Group generate/propagate terms
    always_comb begin
        for (int j = 0; j < NG; j++) gp[j] = group_gp(g[j*CLA_GRP +: CLA_GRP], p[j*CLA_GRP +: CLA_GRP]);
    end

    // Carry into every group, expanded as sum-of-products of group P/G and cin
    always_comb begin
        logic t;
        gc = '0;
        t  = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            for (int i = 0; i <= j; i++) begin
                t = (i == 0) ? cin : gp[(i == 0) ? 0 : i-1].g;
                for (int m = i; m < j; m++) t = t & gp[m].p;
                gc[j] = gc[j] | t;
            end
        end
    end

    // Carry into every bit, looked ahead from its group carry-in
    always_comb begin
        logic t;
        c = '0;
        t = 1'b0;
        for (int j = 0; j < NG; j++) begin
            for (int n = 0; n < CLA_GRP; n++) begin
                for (int i = 0; i <= n; i++) begin
                    t = (i == 0) ? gc[j] : g[j*CLA_GRP + ((i == 0) ? 0 : i-1)];
                    for (int m = i; m < n; m++) t = t & p[j*CLA_GRP + m];
                    c[j*CLA_GRP + n] = c[j*CLA_GRP + n] | t;
                end
            end
        end
    end

    assign sum   = p ^ c;
    assign cout  = gc[NG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage,
// operands shift forward, a single global advance freezes every stage on stall.
module pipelined_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    logic              adv;
    logic [STAGES-1:0] vld_p;
    logic [WIDTH-1:0]  b_eff;

    assign adv           = bus.out_ready || !vld_p[STAGES-1];
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_p[STAGES-1];
    assign b_eff         = bus.sub ? ~bus.b : bus.b;

    // Per-stage valid bits; bubbles travel with the data and are never squeezed out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            for (int k = STAGES - 1; k > 0; k--) vld_p[k] <= vld_p[k-1];
            vld_p[0] <= bus.in_valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int INW = WIDTH - k*SEG;

        logic [INW-1:0]         ina;
        logic [INW-1:0]         inb;
        logic [SEG-1:0]         ss;
        logic                   sc;
        logic                   co;
        logic                   cmsb;
        logic [(k+1)*SEG-1:0]   acc_nxt;
        logic [(k+1)*SEG-1:0]   acc_p;
        logic                   cry_p;

        if (k == 0) begin : g_head
            assign ina     = bus.a;
            assign inb     = b_eff;
            assign sc      = bus.sub | bus.cin;
            assign acc_nxt = ss;
        end else begin : g_body
            assign ina     = g_stage[k-1].g_fwd.rema_p;
            assign inb     = g_stage[k-1].g_fwd.remb_p;
            assign sc      = g_stage[k-1].cry_p;
            assign acc_nxt = {ss, g_stage[k-1].acc_p};
        end

        cla_segment #(.SEG(SEG)) u_seg (
            .a     (ina[SEG-1:0]),
            .b     (inb[SEG-1:0]),
            .cin   (sc),
            .sum   (ss),
            .cout  (co),
            .c_msb (cmsb)
        );

        // ---- stage k register boundary: low sum bits and segment carry ----
        always_ff @(posedge clk) begin
            if (adv) begin
                acc_p <= acc_nxt;
                cry_p <= co;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [INW-SEG-1:0] rema_p;
            logic [INW-SEG-1:0] remb_p;
            logic               cmsb_unused;

            assign cmsb_unused = cmsb;

            // Not-yet-added operand bits move forward with their beat
            always_ff @(posedge clk) begin
                if (adv) begin
                    rema_p <= ina[INW-1:SEG];
                    remb_p <= inb[INW-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_p;
            logic zero_p;
            logic neg_p;

            // Result flags from the final segment and the completed sum
            always_ff @(posedge clk) begin
                if (adv) begin
                    ovf_p  <= cmsb ^ co;
                    zero_p <= (acc_nxt == '0);
                    neg_p  <= acc_nxt[WIDTH-1];
                end
            end

            // Outputs read as zero whenever no result is held
            assign bus.sum  = vld_p[k] ? acc_p : '0;
            assign bus.cout = vld_p[k] & cry_p;
            assign bus.ovf  = vld_p[k] & ovf_p;
            assign bus.zero = vld_p[k] & zero_p;
            assign bus.neg  = vld_p[k] & neg_p;
        end
    end

endmodule
